// File: rtl/count_accumulator_pkg.sv
// Shared types and constants for the count accumulator: FSM states and
// the 5-to-3 count code definition.
package count_accumulator_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = 5;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Codes 6 and 7 cannot come out of a 5-input population count.
  function automatic logic is_legal(input logic [CNT_W-1:0] code);
    return code <= CNT_W'(CNT_MAX);
  endfunction

endpackage

// File: rtl/count_accumulator_if.sv
// Sample input and frame result handshakes of the count accumulator.
interface count_accumulator_if #(
  parameter int unsigned ACC_W = 12
) ();
  import count_accumulator_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_err;
  logic             out_sat;

  modport master (
    output in_valid, in_cnt, out_ready,
    input  in_ready, out_valid, out_sum, out_err, out_sat
  );

  modport slave (
    input  in_valid, in_cnt, out_ready,
    output in_ready, out_valid, out_sum, out_err, out_sat
  );

endinterface

// File: rtl/cntacc_sat_add.sv
// ACC_W-bit accumulator adder. With CNTACC_SAT_EN defined the sum clamps at
// all-ones and o_ovf flags the clamp; otherwise it wraps and o_ovf is 0.
module cntacc_sat_add
  import count_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [CNT_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

`ifdef CNTACC_SAT_EN
  logic [ACC_W:0] w_ext;

  always_comb begin
    w_ext = {1'b0, i_a} + (ACC_W+1)'(i_b);
    o_ovf = w_ext[ACC_W];
    o_sum = w_ext[ACC_W] ? '1 : w_ext[ACC_W-1:0];
  end
`else
  always_comb begin
    o_sum = i_a + ACC_W'(i_b);
    o_ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/count_accumulator.sv
// Sums FRAME_LEN 5-to-3 count codes per frame and presents the frame result
// over a valid/ready handshake. Saturation is selected by CNTACC_SAT_EN.
module count_accumulator
  import count_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  count_accumulator_if.slave  bus
);

  localparam int unsigned       CNT_CW   = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_CW-1:0] LAST_IDX = CNT_CW'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_CW-1:0] r_cnt;
  logic              r_err;
  logic              r_sat;
  logic [ACC_W-1:0]  w_sum;
  logic              w_ovf;
  logic              w_legal;
  logic [CNT_W-1:0]  w_addend;
  logic              w_accept;
  logic              w_last;
  logic              w_release;

  assign w_legal   = is_legal(bus.in_cnt);
  assign w_addend  = w_legal ? bus.in_cnt : '0;
  assign w_accept  = bus.in_valid && (r_state == ACCUM);
  assign w_last    = (r_cnt == LAST_IDX);
  assign w_release = (r_state == DONE) && bus.out_ready;

  cntacc_sat_add #(.ACC_W(ACC_W)) u_add (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && w_last) w_next = DONE;
        DONE:    if (bus.out_ready) w_next = ACCUM;
        default: w_next = ACCUM;
      endcase
    end
  end

  // Result fields are forced to zero whenever no result is offered.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = '0;
    bus.out_err   = 1'b0;
    bus.out_sat   = 1'b0;
    case (r_state)
      ACCUM: bus.in_ready = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_sum   = r_acc;
        bus.out_err   = r_err;
        bus.out_sat   = r_sat;
      end
      default: ;
    endcase
  end

  // Frame datapath; clear wins over any accept or result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_sat <= 1'b0;
    end else if (clr || w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_CW'(1);
      r_err <= r_err | ~w_legal;
      r_sat <= r_sat | w_ovf;
    end
  end

endmodule

// File: tb/tb_count_accumulator.sv
// Scoreboard bench for count_accumulator: a 12-bit and a 4-bit instance share
// one stimulus stream; expectations follow CNTACC_SAT_EN when it is defined.
module tb_count_accumulator;
  import count_accumulator_pkg::*;

  localparam int FL = 16;

  typedef struct {
    int total;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  count_accumulator_if #(.ACC_W(12)) bus12 ();
  count_accumulator_if #(.ACC_W(4))  bus4 ();

  assign bus4.in_valid  = bus12.in_valid;
  assign bus4.in_cnt    = bus12.in_cnt;
  assign bus4.out_ready = bus12.out_ready;

  count_accumulator #(.ACC_W(12), .FRAME_LEN(FL)) dut12 (
    .clk (clk), .rst_n (rst_n), .clr (clr), .bus (bus12)
  );
  count_accumulator #(.ACC_W(4), .FRAME_LEN(FL)) dut4 (
    .clk (clk), .rst_n (rst_n), .clr (clr), .bus (bus4)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb12[$];
  exp_t sb4[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rule: frame total of legal codes, clamped or wrapped to w bits.
  task automatic exp_of(input int total, input int w, output int s, output int sat);
    int max_v;
    max_v = (1 << w) - 1;
`ifdef CNTACC_SAT_EN
    s   = (total > max_v) ? max_v : total;
    sat = (total > max_v) ? 1 : 0;
`else
    s   = total % (1 << w);
    sat = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 12-bit instance.
  always @(negedge clk) begin
    int es, esat;
    if (bus12.out_valid) begin
      if (sb12.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL w12_unexpected: result with sum %0d but none expected", bus12.out_sum);
      end else begin
        exp_of(sb12[0].total, 12, es, esat);
        chk("w12_sum", int'(bus12.out_sum), es);
        chk("w12_err", int'(bus12.out_err), int'(sb12[0].err));
        chk("w12_sat", int'(bus12.out_sat), esat);
        chk("w12_in_ready_done", int'(bus12.in_ready), 0);
        if (bus12.out_ready) void'(sb12.pop_front());
      end
    end else begin
      chk("w12_idle_sum", int'(bus12.out_sum), 0);
      chk("w12_idle_flags", int'({bus12.out_err, bus12.out_sat}), 0);
      chk("w12_in_ready_accum", int'(bus12.in_ready), 1);
    end
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    int es, esat;
    if (bus4.out_valid) begin
      if (sb4.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL w4_unexpected: result with sum %0d but none expected", bus4.out_sum);
      end else begin
        exp_of(sb4[0].total, 4, es, esat);
        chk("w4_sum", int'(bus4.out_sum), es);
        chk("w4_err", int'(bus4.out_err), int'(sb4[0].err));
        chk("w4_sat", int'(bus4.out_sat), esat);
        if (bus4.out_ready) void'(sb4.pop_front());
      end
    end else begin
      chk("w4_idle_sum", int'(bus4.out_sum), 0);
      chk("w4_idle_flags", int'({bus4.out_err, bus4.out_sat}), 0);
    end
  end

  // mode: 0 all 5, 1 all 1 with 7 at sample 3, 2 all 2, 3 random 0..7, 4 random 0..5
  task automatic do_frame(input int mode, input int stall, input bit gaps,
                          input int clr_after, input bit rst_in_done);
    int   codes[FL];
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      case (mode)
        0:       codes[i] = 5;
        1:       codes[i] = (i == 2) ? 7 : 1;
        2:       codes[i] = 2;
        3:       codes[i] = int'($urandom_range(0, 7));
        default: codes[i] = int'($urandom_range(0, 5));
      endcase
    end
    if (clr_after > 0) begin
      for (int i = 0; i < clr_after; i++) begin
        bus12.in_valid = 1'b1;
        bus12.in_cnt   = 3'($urandom_range(0, 7));
        tick();
      end
      clr = 1'b1;
      bus12.in_valid = 1'b1;
      bus12.in_cnt   = 3'd5;
      tick();
      clr = 1'b0;
      bus12.in_valid = 1'b0;
      chk("clr_out_valid", int'(bus12.out_valid), 0);
    end
    bus12.out_ready = (stall == 0);
    e.total = 0;
    e.err   = 1'b0;
    for (int i = 0; i < FL; i++) begin
      bus12.in_valid = 1'b1;
      bus12.in_cnt   = 3'(codes[i]);
      if (codes[i] <= int'(CNT_MAX)) e.total += codes[i];
      else e.err = 1'b1;
      tick();
      if (gaps && i != FL - 1) begin
        bus12.in_valid = 1'b0;
        bus12.in_cnt   = 3'($urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    sb12.push_back(e);
    sb4.push_back(e);
    bus12.in_valid = 1'b1;
    bus12.in_cnt   = 3'($urandom_range(0, 5));
    @(negedge clk);
    chk("latency_w12", int'(bus12.out_valid), 1);
    chk("latency_w4", int'(bus4.out_valid), 1);
    if (rst_in_done) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_w12", int'(bus12.out_valid), 0);
      chk("rst_async_w4", int'(bus4.out_valid), 0);
      void'(sb12.pop_front());
      void'(sb4.pop_front());
      #2;
      rst_n = 1'b1;
      bus12.in_valid  = 1'b0;
      bus12.out_ready = 1'b1;
      tick();
      return;
    end
    repeat (stall) tick();
    bus12.out_ready = 1'b1;
    tick();
    bus12.in_valid = 1'b0;
    chk("next_frame_ready", int'(bus12.in_ready), 1);
    chk("next_frame_idle", int'(bus12.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    clr             = 1'b0;
    bus12.in_valid  = 1'b0;
    bus12.in_cnt    = '0;
    bus12.out_ready = 1'b0;
    #12;
    chk("reset_out_valid", int'(bus12.out_valid), 0);
    chk("reset_sum", int'(bus12.out_sum), 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", int'(bus12.in_ready), 1);

    do_frame(0, 0, 1'b0, 0, 1'b0);
    do_frame(1, 0, 1'b0, 0, 1'b0);
    do_frame(0, 10, 1'b0, 0, 1'b0);
    do_frame(2, 0, 1'b0, 7, 1'b0);
    do_frame(4, 3, 1'b0, 0, 1'b1);
    do_frame(2, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      do_frame((k % 2 == 0) ? 3 : 4, int'($urandom_range(0, 3)), 1'b1, 0, 1'b0);
    end

    repeat (3) tick();
    chk("sb12_drained", sb12.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/count_accumulator.md
COUNT_ACCUMULATOR -- requirements
Module: count_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator/sum width in bits (legal range 4..32).
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame (legal range 1..1024).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous frame abort/clear.
REQ-006 SHALL have port in_valid  input  1  in_cnt valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample.
REQ-008 SHALL have port in_cnt  input  3  5-to-3 count code, legal 0..5.
REQ-009 SHALL have port out_valid  output  1  frame result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  ACC_W  frame sum of legal codes.
REQ-012 SHALL have port out_err  output  1  frame contained an illegal code (6 or 7).
REQ-013 SHALL have port out_sat  output  1  frame sum saturated.

Function
REQ-014 SHALL implement FSM states ACCUM and DONE; reset state ACCUM.
REQ-015 In ACCUM: in_ready=1, out_valid=0; in DONE: in_ready=0, out_valid=1.
REQ-016 Sample accepted only when in_valid && in_ready on a rising edge.
REQ-017 Accepted legal code (0..5) SHALL add its value to acc; illegal code (6,7) adds 0 and sets sticky err.
REQ-018 Sample counter SHALL increment per accepted sample; on the FRAME_LEN-th accepted sample, FSM moves to DONE next cycle.
REQ-019 out_sum/out_err/out_sat SHALL reflect all FRAME_LEN samples including the last; latency last-accept to out_valid = 1 cycle.
REQ-020 out_sum/out_err/out_sat SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1: next cycle state ACCUM, acc/count/err/sat cleared; no same-cycle input bypass (min FRAME_LEN+1 cycles per frame).
REQ-022 Outputs out_sum/out_err/out_sat SHALL read 0 whenever out_valid=0.
REQ-023 clr=1 SHALL take priority over all events: next cycle ACCUM, acc/count/err/sat zero, out_valid=0, any pending sample or result discarded.
REQ-024 in_valid is ignored while in_ready=0; in_cnt may change freely then.

Reset
REQ-025 rst_n low SHALL immediately force state ACCUM, acc=0, count=0, err=0, sat=0, out_valid=0, in_ready=1 after release.
REQ-026 Reset asserted mid-frame or in DONE SHALL discard the frame; no result is emitted.

Configuration
REQ-027 Macro CNTACC_SAT_EN defined: acc SHALL clamp at 2^ACC_W-1 and set sticky sat on any clamped add.
REQ-028 Macro CNTACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; out_sat tied 0.

Structure
REQ-029 Shared package SHALL hold FSM state enum (ACCUM, DONE), code constants CNT_MAX=5 and CNT_W=3.
REQ-030 One sub-module cntacc_sat_add (ACC_W-bit adder with optional clamp and overflow flag) SHALL implement the add.
REQ-031 Counter width SHALL be clog2(FRAME_LEN+1); no other sub-modules.

Verification
REQ-032 Defaults, 16 samples of code 5, out_ready=1 -> out_valid one cycle after last accept, out_sum=80, err=0, sat=0.
REQ-033 Frame with code 7 at sample 3, others 1 -> out_sum=15, out_err=1.
REQ-034 out_ready held 0 for 10 cycles in DONE -> in_ready=0 and out_sum stable for all 10; next frame starts the cycle after acceptance.
REQ-035 ACC_W=4, SAT_EN defined, 16 x code 5 -> out_sum=15, out_sat=1; SAT_EN undefined -> out_sum=0 (80 mod 16), out_sat=0.
REQ-036 clr asserted after 7 samples, then 16 x code 2 -> single result out_sum=32; rst_n pulsed in DONE -> out_valid drops asynchronously, no result.
